gray_tracker: RTL and testbench

- Downstream consumer of the 3-bit Gray-code counter; samples its code and sticky overflow flag.
- Decodes the code to binary and extends it with an epoch (wrap) counter into a wide running count.
- Checks every observed transition for a legal single-step Gray increment; counts errors and drops into a fault state after too many.

---
 rtl/gray_tracker_if.sv | 32 +++
 rtl/gray_tracker.sv | 133 +++++++++++++
 tb/tb_gray_tracker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gray_tracker_if.sv
// Bus between the Gray-code counter side and gray_tracker.
// The slave modport belongs to the tracker. The master modport belongs to whoever drives the samples.
// Handshake: GrayIn/OvfIn are meaningful only in a cycle where Valid=1.
// There is no backpressure; every Valid=1 cycle is consumed on that rising edge.
// Clear is a synchronous command that wins over Valid.
interface gray_tracker_if #(
  parameter int WIDTH   = 3,
  parameter int EPOCH_W = 8
);
  logic                       Valid;
  logic [WIDTH-1:0]           GrayIn;
  logic                       OvfIn;
  logic                       Clear;
  logic [WIDTH-1:0]           BinOut;
  logic [EPOCH_W+WIDTH-1:0]   Count;
  logic                       Step;
  logic                       Wrap;
  logic                       Err;
  logic [3:0]                 ErrCnt;
  logic                       Locked;
  logic [1:0]                 DbgState;

  modport slave (
    input  Valid, GrayIn, OvfIn, Clear,
    output BinOut, Count, Step, Wrap, Err, ErrCnt, Locked, DbgState
  );

  modport master (
    output Valid, GrayIn, OvfIn, Clear,
    input  BinOut, Count, Step, Wrap, Err, ErrCnt, Locked, DbgState
  );
endinterface

// File: rtl/gray_tracker.sv
// Tracks an upstream Gray-code counter.
// It decodes each accepted code and extends it with a wrap (epoch) counter.
// It flags illegal transitions, and after ERR_LIMIT errors it parks in FAULT.
module gray_tracker #(
  parameter int WIDTH     = 3,
  parameter int EPOCH_W   = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   BIN_MAX   = '1;
  localparam logic [WIDTH-1:0]   BIN_ZERO  = '0;
  localparam logic [WIDTH-1:0]   BIN_ONE   = 1;
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = 1;
  localparam logic [3:0]         LIMIT     = 4'(ERR_LIMIT);

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_prev, w_prev_nxt;
  logic [WIDTH-1:0]    r_bin, w_bin_nxt;
  logic [EPOCH_W-1:0]  r_epoch, w_epoch_nxt;
  logic [3:0]          r_errcnt, w_errcnt_nxt;
  logic                r_step, w_step_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                r_err, w_err_nxt;
  logic                r_locked;
  logic [WIDTH-1:0]    w_dec;
  logic [3:0]          w_errcnt_inc;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign w_dec        = gray2bin(bus.GrayIn);
  assign w_errcnt_inc = (r_errcnt == 4'd15) ? 4'd15 : r_errcnt + 4'd1;

  // Next-state and next-output logic; Clear overrides everything else
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_bin_nxt    = r_bin;
    w_epoch_nxt  = r_epoch;
    w_errcnt_nxt = r_errcnt;
    w_step_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    if (bus.Clear) begin
      w_state_nxt  = S_INIT;
      w_prev_nxt   = '0;
      w_bin_nxt    = '0;
      w_epoch_nxt  = '0;
      w_errcnt_nxt = '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (bus.Valid) begin
            w_prev_nxt  = bus.GrayIn;
            w_bin_nxt   = w_dec;
            w_state_nxt = S_TRACK;
          end
        end
        S_TRACK: begin
          // A repeated code means the counter was idle, so nothing changes
          if (bus.Valid && (bus.GrayIn != r_prev)) begin
            w_prev_nxt = bus.GrayIn;
            w_bin_nxt  = w_dec;
            if ((r_bin != BIN_MAX) && (w_dec == r_bin + BIN_ONE)) begin
              w_step_nxt = 1'b1;
            end else if ((r_bin == BIN_MAX) && (w_dec == BIN_ZERO) && bus.OvfIn) begin
              w_step_nxt  = 1'b1;
              w_wrap_nxt  = 1'b1;
              w_epoch_nxt = r_epoch + EPOCH_ONE;
            end else begin
              // Illegal step: resync to the new sample, keep the epoch
              w_err_nxt    = 1'b1;
              w_errcnt_nxt = w_errcnt_inc;
              if (w_errcnt_inc >= LIMIT) w_state_nxt = S_FAULT;
            end
          end
        end
        default: begin
          // FAULT: frozen until Clear or Reset
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_INIT;
      r_prev   <= '0;
      r_bin    <= '0;
      r_epoch  <= '0;
      r_errcnt <= '0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_bin    <= w_bin_nxt;
      r_epoch  <= w_epoch_nxt;
      r_errcnt <= w_errcnt_nxt;
      r_step   <= w_step_nxt;
      r_wrap   <= w_wrap_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == S_TRACK);
    end
  end

  assign bus.BinOut   = r_bin;
  assign bus.Count    = {r_epoch, r_bin};
  assign bus.Step     = r_step;
  assign bus.Wrap     = r_wrap;
  assign bus.Err      = r_err;
  assign bus.ErrCnt   = r_errcnt;
  assign bus.Locked   = r_locked;
  assign bus.DbgState = r_state;

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker with WIDTH=3, EPOCH_W=8, ERR_LIMIT=3.
module tb_gray_tracker;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  gray_tracker_if #(.WIDTH(3), .EPOCH_W(8)) bus ();

  gray_tracker #(.WIDTH(3), .EPOCH_W(8), .ERR_LIMIT(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [2:0] gray_tab [0:7];

  // Drive one sample, let one rising edge take it, then return to idle inputs
  task automatic apply(input logic v, input logic [2:0] g, input logic o, input logic c);
    bus.Valid  = v;
    bus.GrayIn = g;
    bus.OvfIn  = o;
    bus.Clear  = c;
    @(posedge Clk);
    #1;
    bus.Valid = 1'b0;
    bus.Clear = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.Valid = 1'b0; bus.GrayIn = 3'b000; bus.OvfIn = 1'b0; bus.Clear = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_total++;
    if (bus.Count !== 11'd0) $display("FAIL reset_count got=%0d exp=0", bus.Count); else n_pass++;
    n_total++;
    if ({bus.Locked, bus.Step, bus.Wrap, bus.Err, bus.ErrCnt} !== 8'h00)
      $display("FAIL reset_flags got=%b exp=00000000", {bus.Locked, bus.Step, bus.Wrap, bus.Err, bus.ErrCnt});
    else n_pass++;
    Reset = 1'b1;
  endtask

  task automatic test_count_up();
    apply(1'b1, 3'b000, 1'b0, 1'b0);
    n_total++;
    if ({bus.Locked, bus.Step, bus.BinOut} !== 5'b10_000)
      $display("FAIL lock_first got=%b exp=10000", {bus.Locked, bus.Step, bus.BinOut});
    else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      apply(1'b1, gray_tab[i], 1'b0, 1'b0);
      n_total++;
      if ({bus.Step, bus.Err, bus.BinOut} !== {2'b10, 3'(i)})
        $display("FAIL step_%0d got=%b exp=%b", i, {bus.Step, bus.Err, bus.BinOut}, {2'b10, 3'(i)});
      else n_pass++;
    end
    apply(1'b0, 3'b101, 1'b0, 1'b0);
    n_total++;
    if ({bus.Step, bus.Count} !== {1'b0, 11'd6})
      $display("FAIL count_six got=%b exp=%b", {bus.Step, bus.Count}, {1'b0, 11'd6});
    else n_pass++;
  endtask

  task automatic test_wrap();
    int wraps;
    apply(1'b1, 3'b100, 1'b1, 1'b0);
    n_total++;
    if ({bus.Step, bus.Wrap, bus.BinOut} !== 5'b10_111)
      $display("FAIL to_seven got=%b exp=10111", {bus.Step, bus.Wrap, bus.BinOut});
    else n_pass++;
    apply(1'b1, 3'b000, 1'b1, 1'b0);
    n_total++;
    if ({bus.Step, bus.Wrap, bus.Err, bus.Count} !== {3'b110, 11'd8})
      $display("FAIL first_wrap got=%b exp=%b", {bus.Step, bus.Wrap, bus.Err, bus.Count}, {3'b110, 11'd8});
    else n_pass++;
    apply(1'b0, 3'b000, 1'b0, 1'b0);
    n_total++;
    if ({bus.Step, bus.Wrap} !== 2'b00)
      $display("FAIL wrap_pulse_len got=%b exp=00", {bus.Step, bus.Wrap});
    else n_pass++;
    wraps = 0;
    for (int w = 1; w < 256; w++) begin
      for (int i = 1; i <= 7; i++) apply(1'b1, gray_tab[i], 1'b1, 1'b0);
      apply(1'b1, 3'b000, 1'b1, 1'b0);
      if (bus.Wrap === 1'b1) wraps++;
    end
    n_total++;
    if (wraps != 255) $display("FAIL wrap_pulses got=%0d exp=255", wraps); else n_pass++;
    n_total++;
    if ({bus.Count, bus.ErrCnt} !== {11'd0, 4'd0})
      $display("FAIL epoch_rollover got=%0d/%0d exp=0/0", bus.Count, bus.ErrCnt);
    else n_pass++;
  endtask

  task automatic test_bad_wrap();
    for (int i = 1; i <= 7; i++) apply(1'b1, gray_tab[i], 1'b0, 1'b0);
    apply(1'b1, 3'b000, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) apply(1'b1, gray_tab[i], 1'b0, 1'b0);
    n_total++;
    if (bus.Count !== 11'd15) $display("FAIL pre_bad_wrap got=%0d exp=15", bus.Count); else n_pass++;
    apply(1'b1, 3'b000, 1'b0, 1'b0);
    n_total++;
    if ({bus.Err, bus.Step, bus.Wrap, bus.Locked, bus.ErrCnt} !== 8'b1001_0001)
      $display("FAIL bad_wrap_flags got=%b exp=10010001", {bus.Err, bus.Step, bus.Wrap, bus.Locked, bus.ErrCnt});
    else n_pass++;
    n_total++;
    if (bus.Count !== 11'd8) $display("FAIL bad_wrap_count got=%0d exp=8", bus.Count); else n_pass++;
  endtask

  task automatic test_fault();
    apply(1'b0, 3'b000, 1'b0, 1'b1);
    n_total++;
    if ({bus.Locked, bus.ErrCnt, bus.Count} !== {1'b0, 4'd0, 11'd0})
      $display("FAIL clear_track got=%b exp=0", {bus.Locked, bus.ErrCnt, bus.Count});
    else n_pass++;
    apply(1'b1, 3'b001, 1'b0, 1'b0);
    apply(1'b1, 3'b110, 1'b0, 1'b0);
    n_total++;
    if ({bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked} !== {1'b1, 4'd1, 3'd4, 1'b1})
      $display("FAIL err1 got=%b exp=%b", {bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked}, {1'b1, 4'd1, 3'd4, 1'b1});
    else n_pass++;
    apply(1'b1, 3'b000, 1'b0, 1'b0);
    n_total++;
    if ({bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked} !== {1'b1, 4'd2, 3'd0, 1'b1})
      $display("FAIL err2 got=%b exp=%b", {bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked}, {1'b1, 4'd2, 3'd0, 1'b1});
    else n_pass++;
    apply(1'b1, 3'b011, 1'b0, 1'b0);
    n_total++;
    if ({bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked} !== {1'b1, 4'd3, 3'd2, 1'b0})
      $display("FAIL err3 got=%b exp=%b", {bus.Err, bus.ErrCnt, bus.BinOut, bus.Locked}, {1'b1, 4'd3, 3'd2, 1'b0});
    else n_pass++;
    apply(1'b1, 3'b001, 1'b0, 1'b0);
    n_total++;
    if ({bus.Err, bus.Step, bus.ErrCnt, bus.BinOut, bus.Locked} !== {2'b00, 4'd3, 3'd2, 1'b0})
      $display("FAIL fault_frozen got=%b exp=%b", {bus.Err, bus.Step, bus.ErrCnt, bus.BinOut, bus.Locked}, {2'b00, 4'd3, 3'd2, 1'b0});
    else n_pass++;
    apply(1'b1, 3'b011, 1'b0, 1'b1);
    n_total++;
    if ({bus.Locked, bus.ErrCnt, bus.BinOut} !== {1'b0, 4'd0, 3'd0})
      $display("FAIL clear_fault got=%b exp=%b", {bus.Locked, bus.ErrCnt, bus.BinOut}, {1'b0, 4'd0, 3'd0});
    else n_pass++;
    apply(1'b1, 3'b011, 1'b0, 1'b0);
    n_total++;
    if ({bus.Locked, bus.Step, bus.Err, bus.BinOut} !== {3'b100, 3'd2})
      $display("FAIL relock got=%b exp=%b", {bus.Locked, bus.Step, bus.Err, bus.BinOut}, {3'b100, 3'd2});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply(1'b0, 3'b000, 1'b0, 1'b1);
    apply(1'b1, 3'b000, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) apply(1'b1, gray_tab[i], 1'b0, 1'b0);
    apply(1'b1, 3'b000, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) apply(1'b1, gray_tab[i], 1'b0, 1'b0);
    n_total++;
    if (bus.Count !== 11'd13) $display("FAIL pre_reset_count got=%0d exp=13", bus.Count); else n_pass++;
    #3;
    Reset = 1'b0;
    #1;
    n_total++;
    if ({bus.Count, bus.ErrCnt, bus.Locked} !== {11'd0, 4'd0, 1'b0})
      $display("FAIL async_reset got=%b exp=0", {bus.Count, bus.ErrCnt, bus.Locked});
    else n_pass++;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    apply(1'b1, 3'b010, 1'b0, 1'b0);
    n_total++;
    if ({bus.Locked, bus.Step, bus.Wrap, bus.Err, bus.BinOut} !== {4'b1000, 3'd3})
      $display("FAIL post_reset_lock got=%b exp=%b", {bus.Locked, bus.Step, bus.Wrap, bus.Err, bus.BinOut}, {4'b1000, 3'd3});
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 3'b010, 1'b0, 1'b0);
      n_total++;
      if ({bus.Step, bus.Wrap, bus.Err, bus.BinOut, bus.ErrCnt} !== {3'b000, 3'd3, 4'd0})
        $display("FAIL repeat_hold_%0d got=%b exp=%b", k, {bus.Step, bus.Wrap, bus.Err, bus.BinOut, bus.ErrCnt}, {3'b000, 3'd3, 4'd0});
      else n_pass++;
    end
  endtask

  initial begin
    gray_tab[0] = 3'b000; gray_tab[1] = 3'b001; gray_tab[2] = 3'b011; gray_tab[3] = 3'b010;
    gray_tab[4] = 3'b110; gray_tab[5] = 3'b111; gray_tab[6] = 3'b101; gray_tab[7] = 3'b100;
    test_reset();
    test_count_up();
    test_wrap();
    test_bad_wrap();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
